// File: rtl/branch_sequencer_if.sv
// Branch sequencer bus: request/handshake toward the sequencer and the
// resulting PC and status back to the fetch side.
interface branch_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic            br_req;
    logic            br_ready;
    logic [2:0]      br_op;
    logic [PC_W-1:0] br_target;
    logic [7:0]      cmp_y;
    logic            err_clr;
    logic [PC_W-1:0] pc;
    logic            br_done;
    logic            br_taken;
    logic            stk_err;
    logic [SP_W-1:0] sp;

    // Requesting side (compare stage / control)
    modport master (
        output br_req, br_op, br_target, cmp_y, err_clr,
        input  br_ready, pc, br_done, br_taken, stk_err, sp
    );

    // Sequencer side
    modport slave (
        input  br_req, br_op, br_target, cmp_y, err_clr,
        output br_ready, pc, br_done, br_taken, stk_err, sp
    );
endinterface

// File: rtl/branch_sequencer.sv
// Program-counter sequencer fed by the 8-bit compare stage.
// Resolves INC/JMP/BRT/BRF/CALL/RET through IDLE -> EVAL -> UPDATE.
// Optional feature macro: BR_STACK_EN enables the return stack and CALL/RET;
// without it sp reads 0 and CALL/RET are handled as illegal opcodes.
module branch_sequencer #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_sequencer_if.slave  bus
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRT  = 3'b010;
    localparam logic [2:0] OP_BRF  = 3'b011;
`ifdef BR_STACK_EN
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam int         IX_W    = $clog2(DEPTH);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_ready;
    logic            w_accept;

    // Request captured at acceptance
    logic [2:0]      r_op_p0;
    logic [PC_W-1:0] r_target_p0;
    logic [7:0]      r_cmp_p0;

    // Decision registered in EVAL, applied in UPDATE
    logic [PC_W-1:0] r_npc_p1;
    logic            r_taken_p1;
    logic            r_err_p1;
    logic            r_push_p1;
    logic            r_pop_p1;

    // Combinational decision
    logic [PC_W-1:0] w_seq;
    logic            w_cond;
    logic [PC_W-1:0] w_npc;
    logic            w_taken;
    logic            w_err;
    logic            w_push;
    logic            w_pop;

    // Architectural state
    logic [PC_W-1:0] r_pc;
    logic            r_done;
    logic            r_taken;
    logic            r_err;
    logic [SP_W-1:0] r_sp;

`ifdef BR_STACK_EN
    logic [PC_W-1:0] r_stack [DEPTH];
    logic [SP_W-1:0] w_sp_dec;
`endif

    // State register; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.br_req) w_state_nxt = S_EVAL;
            end
            S_EVAL:   w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = bus.br_req & w_ready;

    // ---- stage p0: capture request operands at acceptance ----
    // Operands are sampled only here; later changes on the bus are ignored
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_p0     <= bus.br_op;
            r_target_p0 <= bus.br_target;
            r_cmp_p0    <= bus.cmp_y;
        end
    end

    assign w_seq  = r_pc + PC_W'(1);
    assign w_cond = |r_cmp_p0;
`ifdef BR_STACK_EN
    assign w_sp_dec = r_sp - SP_W'(1);
`endif

    // Branch resolution from captured operands and current pc/sp
    always_comb begin
        w_npc   = w_seq;
        w_taken = 1'b0;
        w_err   = 1'b0;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        case (r_op_p0)
            OP_INC: ;
            OP_JMP: begin
                w_npc   = r_target_p0;
                w_taken = 1'b1;
            end
            OP_BRT: begin
                if (w_cond) begin
                    w_npc   = r_target_p0;
                    w_taken = 1'b1;
                end
            end
            OP_BRF: begin
                if (!w_cond) begin
                    w_npc   = r_target_p0;
                    w_taken = 1'b1;
                end
            end
`ifdef BR_STACK_EN
            OP_CALL: begin
                if (r_sp != SP_W'(DEPTH)) begin
                    w_npc   = r_target_p0;
                    w_taken = 1'b1;
                    w_push  = 1'b1;
                end else begin
                    w_err   = 1'b1;
                end
            end
            OP_RET: begin
                if (r_sp != '0) begin
                    w_npc   = r_stack[w_sp_dec[IX_W-1:0]];
                    w_taken = 1'b1;
                    w_pop   = 1'b1;
                end else begin
                    w_err   = 1'b1;
                end
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    // ---- stage p1: register the EVAL decision ----
    always_ff @(posedge clk) begin
        if (r_state == S_EVAL) begin
            r_npc_p1   <= w_npc;
            r_taken_p1 <= w_taken;
            r_err_p1   <= w_err;
            r_push_p1  <= w_push;
            r_pop_p1   <= w_pop;
        end
    end

    // ---- UPDATE: commit pc, done pulse, taken flag, sticky error ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_taken <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= (r_state == S_UPDATE);
            if (r_state == S_UPDATE) begin
                r_pc    <= r_npc_p1;
                r_taken <= r_taken_p1;
            end
            if ((r_state == S_UPDATE) && r_err_p1) r_err <= 1'b1;
            else if (bus.err_clr)                  r_err <= 1'b0;
        end
    end

`ifdef BR_STACK_EN
    // Stack pointer moves at the UPDATE edge only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (r_state == S_UPDATE) begin
            if (r_push_p1)     r_sp <= r_sp + SP_W'(1);
            else if (r_pop_p1) r_sp <= w_sp_dec;
        end
    end

    // Return-address storage; pc is still the caller's pc here so seq is the return point
    always_ff @(posedge clk) begin
        if ((r_state == S_UPDATE) && r_push_p1) begin
            r_stack[r_sp[IX_W-1:0]] <= w_seq;
        end
    end
`else
    assign r_sp = SP_W'(0);
`endif

    assign bus.br_ready = w_ready;
    assign bus.pc       = r_pc;
    assign bus.br_done  = r_done;
    assign bus.br_taken = r_taken;
    assign bus.stk_err  = r_err;
    assign bus.sp       = r_sp;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: reset, branch resolution, wrap,
// sticky error/clear, return stack (when BR_STACK_EN), busy-hold and reset-in-EVAL.
module tb_branch_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    branch_sequencer_if #(.PC_W(8), .DEPTH(4)) bus ();

    branch_sequencer #(.PC_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; checks timing of br_done and the resulting state
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] tgt,
                          input logic [7:0] cmp, input logic [7:0] exp_pc,
                          input logic exp_taken, input logic exp_err, input int exp_sp);
        @(negedge clk);
        chk({tag, ".ready_in"}, 32'(bus.br_ready), 32'd1);
        bus.br_req    = 1'b1;
        bus.br_op     = op;
        bus.br_target = tgt;
        bus.cmp_y     = cmp;
        @(negedge clk);
        bus.br_req    = 1'b0;
        bus.br_op     = 3'b000;
        bus.br_target = 8'h00;
        bus.cmp_y     = 8'h00;
        chk({tag, ".busy"}, 32'(bus.br_ready), 32'd0);
        @(negedge clk);
        chk({tag, ".done_early"}, 32'(bus.br_done), 32'd0);
        @(negedge clk);
        chk({tag, ".done"}, 32'(bus.br_done), 32'd1);
        chk({tag, ".pc"}, 32'(bus.pc), 32'(exp_pc));
        chk({tag, ".taken"}, 32'(bus.br_taken), 32'(exp_taken));
        chk({tag, ".err"}, 32'(bus.stk_err), 32'(exp_err));
        chk({tag, ".sp"}, 32'(bus.sp), 32'(exp_sp));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(bus.br_done), 32'd0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_clr", 32'(bus.stk_err), 32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.br_req    = 1'b0;
        bus.br_op     = 3'b000;
        bus.br_target = 8'h00;
        bus.cmp_y     = 8'h00;
        bus.err_clr   = 1'b0;

        // Reset for two cycles
        repeat (2) @(negedge clk);
        chk("rst.pc", 32'(bus.pc), 32'h0);
        chk("rst.sp", 32'(bus.sp), 32'h0);
        chk("rst.ready", 32'(bus.br_ready), 32'd1);
        chk("rst.done", 32'(bus.br_done), 32'd0);
        chk("rst.err", 32'(bus.stk_err), 32'd0);
        rst_n = 1'b1;

        // Branch resolution
        run_op("jmp5",     3'b001, 8'h05, 8'h00, 8'h05, 1'b1, 1'b0, 0);
        run_op("brt_t",    3'b010, 8'h40, 8'h01, 8'h40, 1'b1, 1'b0, 0);
        run_op("brt_nt",   3'b010, 8'h40, 8'h00, 8'h41, 1'b0, 1'b0, 0);
        run_op("brf_t",    3'b011, 8'h10, 8'h00, 8'h10, 1'b1, 1'b0, 0);
        run_op("brf_nt",   3'b011, 8'h20, 8'h80, 8'h11, 1'b0, 1'b0, 0);
        run_op("brt_msb",  3'b010, 8'h30, 8'h80, 8'h30, 1'b1, 1'b0, 0);
        run_op("inc",      3'b000, 8'h77, 8'hFF, 8'h31, 1'b0, 1'b0, 0);

        // Wrap 0xFF -> 0x00
        run_op("jmpff",    3'b001, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, 0);
        run_op("wrap",     3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0);

        // Illegal opcodes and sticky error
        run_op("ill110",   3'b110, 8'h55, 8'h00, 8'h01, 1'b0, 1'b1, 0);
        run_op("jmp_keep", 3'b001, 8'h02, 8'h00, 8'h02, 1'b1, 1'b1, 0);
        clear_err();
        // err_clr held through an error-setting UPDATE: set wins
        bus.err_clr = 1'b1;
        run_op("ill111",   3'b111, 8'h55, 8'h00, 8'h03, 1'b0, 1'b1, 0);
        bus.err_clr = 1'b0;
        clear_err();

`ifdef BR_STACK_EN
        run_op("s.jmp",    3'b001, 8'h10, 8'h00, 8'h10, 1'b1, 1'b0, 0);
        run_op("call1",    3'b100, 8'h20, 8'h00, 8'h20, 1'b1, 1'b0, 1);
        run_op("call2",    3'b100, 8'h30, 8'h00, 8'h30, 1'b1, 1'b0, 2);
        run_op("call3",    3'b100, 8'h40, 8'h00, 8'h40, 1'b1, 1'b0, 3);
        run_op("call4",    3'b100, 8'h50, 8'h00, 8'h50, 1'b1, 1'b0, 4);
        run_op("call_ovf", 3'b100, 8'h60, 8'h00, 8'h51, 1'b0, 1'b1, 4);
        run_op("ret1",     3'b101, 8'h00, 8'h00, 8'h41, 1'b1, 1'b1, 3);
        run_op("ret2",     3'b101, 8'h00, 8'h00, 8'h31, 1'b1, 1'b1, 2);
        run_op("ret3",     3'b101, 8'h00, 8'h00, 8'h21, 1'b1, 1'b1, 1);
        run_op("ret4",     3'b101, 8'h00, 8'h00, 8'h11, 1'b1, 1'b1, 0);
        run_op("ret_unf",  3'b101, 8'h00, 8'h00, 8'h12, 1'b0, 1'b1, 0);
        clear_err();
`else
        run_op("s.jmp",    3'b001, 8'h10, 8'h00, 8'h10, 1'b1, 1'b0, 0);
        run_op("call_ill", 3'b100, 8'h20, 8'h00, 8'h11, 1'b0, 1'b1, 0);
        clear_err();
        run_op("ret_ill",  3'b101, 8'h00, 8'h00, 8'h12, 1'b0, 1'b1, 0);
        clear_err();
`endif

        // br_req held high through EVAL/UPDATE: exactly one accept
        @(negedge clk);
        bus.br_req = 1'b1;
        bus.br_op  = 3'b000;
        @(negedge clk);
        chk("hold.busy1", 32'(bus.br_ready), 32'd0);
        @(negedge clk);
        chk("hold.busy2", 32'(bus.br_ready), 32'd0);
        @(negedge clk);
        bus.br_req = 1'b0;
        chk("hold.done", 32'(bus.br_done), 32'd1);
        chk("hold.pc", 32'(bus.pc), 32'h13);
        @(negedge clk);
        chk("hold.done_off", 32'(bus.br_done), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold.pc_stable", 32'(bus.pc), 32'h13);
        chk("hold.ready", 32'(bus.br_ready), 32'd1);

        // Reset while in EVAL: op dropped, no done pulse
        @(negedge clk);
        bus.br_req    = 1'b1;
        bus.br_op     = 3'b001;
        bus.br_target = 8'h33;
        @(negedge clk);
        bus.br_req = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstev.pc", 32'(bus.pc), 32'h0);
        chk("rstev.done", 32'(bus.br_done), 32'd0);
        chk("rstev.ready", 32'(bus.br_ready), 32'd1);
        repeat (2) @(negedge clk);
        chk("rstev.done2", 32'(bus.br_done), 32'd0);
        chk("rstev.pc2", 32'(bus.pc), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
